// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the RLS datapath arithmetic blocks.
package fxp_pkg;

  localparam int NBITS_RLS = 32;
  localparam int FRAC_RLS  = 16;
  localparam int MAXW      = 64;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_mode_e;

  // Patterns are right-aligned in MAXW bits; callers truncate to their width.
  function automatic logic [MAXW-1:0] max_pos(input int unsigned w);
    return (MAXW'(1) << (w - 1)) - MAXW'(1);
  endfunction

  function automatic logic [MAXW-1:0] max_neg(input int unsigned w);
    return MAXW'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/fxp_mult_pipe_if.sv
// Operand/result handshake bundle for the pipelined fixed-point multiplier.
interface fxp_mult_pipe_if
  import fxp_pkg::*;
#(
  parameter int NBITS = NBITS_RLS
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] res;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, res, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, res, ovf
  );
endinterface

// File: rtl/fxp_round_sat.sv
// Combinational Q-format rescale of a full-width product: round/truncate, then clamp or wrap.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int NBITS    = NBITS_RLS,
  parameter int FRAC     = FRAC_RLS,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1
) (
  input  logic signed [2*NBITS-1:0] p,
  output logic        [NBITS-1:0]   res,
  output logic                      ovf
);

  localparam int W   = 2 * NBITS + 1;
  localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam bit DO_RND = (ROUND == int'(RND_HALF_UP)) && (FRAC > 0);
  localparam logic signed [W-1:0]     RND_ADD = DO_RND ? (W'(1) << RSH) : '0;
  localparam logic        [NBITS-1:0] MAXP    = NBITS'(max_pos(NBITS));
  localparam logic        [NBITS-1:0] MAXN    = NBITS'(max_neg(NBITS));

  logic signed [W-1:0]     r;
  logic        [W-NBITS:0] hi;

  always_comb begin
    // One guard bit above the product so the rounding add never wraps.
    r   = (W'(p) + RND_ADD) >>> FRAC;
    hi  = r[W-1:NBITS-1];
    ovf = !((&hi) || !(|hi));
    res = r[NBITS-1:0];
    if (ovf && (SATURATE != 0)) begin
      res = r[W-1] ? MAXN : MAXP;
    end
  end

endmodule

// File: rtl/fxp_mult_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready flow control and a global stall.
module fxp_mult_pipe
  import fxp_pkg::*;
#(
  parameter int NBITS    = NBITS_RLS,
  parameter int FRAC     = FRAC_RLS,
  parameter int LATENCY  = 3,
  parameter int SATURATE = 1,
  parameter int ROUND    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  fxp_mult_pipe_if.slave   bus,
  input  logic             clr_ovf,
  output logic             ovf_sticky,
  output logic             busy
);

  localparam int PW = 2 * NBITS;
  localparam int unsigned NP = LATENCY - 2;

  logic                    advance;
  logic [LATENCY-1:0]      vld;
  logic signed [NBITS-1:0] a_q, b_q;
  logic signed [PW-1:0]    p_last;
  logic [NBITS-1:0]        res_c, res_q;
  logic                    ovf_c, ovf_q;

  assign advance = !vld[LATENCY-1] || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      vld   <= {vld[LATENCY-2:0], bus.in_valid};
      a_q   <= bus.a;
      b_q   <= bus.b;
      res_q <= res_c;
      ovf_q <= ovf_c;
    end
  end

  // With LATENCY=2 the product is formed combinationally in front of the final stage.
  generate
    if (NP == 0) begin : g_np0
      assign p_last = PW'(a_q) * PW'(b_q);
    end else begin : g_prod
      logic signed [PW-1:0] pr [NP];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < NP; i++) pr[i] <= '0;
        end else if (advance) begin
          pr[0] <= PW'(a_q) * PW'(b_q);
          for (int unsigned i = 1; i < NP; i++) pr[i] <= pr[i-1];
        end
      end

      assign p_last = pr[NP-1];
    end
  endgenerate

  fxp_round_sat #(
    .NBITS    (NBITS),
    .FRAC     (FRAC),
    .ROUND    (ROUND),
    .SATURATE (SATURATE)
  ) u_round_sat (
    .p   (p_last),
    .res (res_c),
    .ovf (ovf_c)
  );

  // A delivered overflow takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (vld[LATENCY-1] && bus.out_ready && ovf_q) begin
      ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld[LATENCY-1];
  assign bus.res       = res_q;
  assign bus.ovf       = ovf_q;
  assign busy          = |vld;

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Bench for fxp_mult_pipe: Q8.8 in three configs (round+sat, trunc+sat, round+wrap), lockstep stimulus.
module tb_fxp_mult_pipe;

  localparam int NB  = 16;
  localparam int FR  = 8;
  localparam int LAT = 3;
  localparam int NRAND = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          clr_ovf = 1'b0;
  logic [NB-1:0] a = '0;
  logic [NB-1:0] b = '0;
  logic          in_ready, out_valid;
  logic [2:0]    sticky, busy, ovf_w;
  logic [NB-1:0] res_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fxp_mult_pipe_if #(.NBITS(NB)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.out_ready = out_ready;
    assign res_w[g]      = bus.res;
    assign ovf_w[g]      = bus.ovf;
    if (g == 0) begin : g_hs
      assign in_ready  = bus.in_ready;
      assign out_valid = bus.out_valid;
    end
    fxp_mult_pipe #(
      .NBITS    (NB),
      .FRAC     (FR),
      .LATENCY  (LAT),
      .SATURATE ((g == 2) ? 0 : 1),
      .ROUND    ((g == 1) ? 0 : 1)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .clr_ovf    (clr_ovf),
      .ovf_sticky (sticky[g]),
      .busy       (busy[g])
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact product, optional +half-LSB, floor shift, then range test.
  function automatic void model(input logic [NB-1:0] ia, input logic [NB-1:0] ib, input int d,
                                output logic [NB-1:0] r, output logic o);
    longint p, q;
    p = longint'($signed(ia)) * longint'($signed(ib));
    q = (p + ((d != 1) ? (longint'(1) << (FR - 1)) : longint'(0))) >>> FR;
    o = (q > 32767) || (q < -32768);
    if (o && (d != 2)) r = (q < 0) ? 16'h8000 : 16'h7FFF;
    else               r = q[NB-1:0];
  endfunction

  typedef struct packed {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
  } item_t;

  item_t q_in[$];
  item_t it;
  int    n_out = 0;
  bit    sticky_m [3];
  logic [NB-1:0] er;
  logic          eo;
  logic          hs;
  logic [2:0]    setv;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_in.delete();
      for (int d = 0; d < 3; d++) sticky_m[d] = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) check($sformatf("sticky%0d", d), sticky[d], sticky_m[d]);
      hs   = out_valid && out_ready;
      setv = '0;
      if (hs) begin
        n_out++;
        check("out_has_expected", q_in.size() > 0, 1);
        if (q_in.size() > 0) begin
          it = q_in.pop_front();
          for (int d = 0; d < 3; d++) begin
            model(it.a, it.b, d, er, eo);
            check($sformatf("res%0d a=%h b=%h", d, it.a, it.b), res_w[d], er);
            check($sformatf("ovf%0d a=%h b=%h", d, it.a, it.b), ovf_w[d], eo);
            setv[d] = eo;
          end
        end
      end
      for (int d = 0; d < 3; d++) begin
        if (setv[d]) sticky_m[d] = 1'b1;
        else if (clr_ovf) sticky_m[d] = 1'b0;
      end
      if (in_valid && in_ready) q_in.push_back('{a: a, b: b});
    end
  end

  task automatic send(input logic [NB-1:0] ia, input logic [NB-1:0] ib);
    int n = 0;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 1000);
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 50);
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic consume();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB-1:0] rv();
    case ($urandom % 8)
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      default: return NB'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n0;
    logic [NB-1:0] held;
    bit done;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sticky", sticky, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_res", res_w[0], 0);
    check("rst_ovf", ovf_w, 0);
    @(posedge clk);
    #1;

    send(16'h0180, 16'h0200);
    wait_out(cyc);
    check("latency", cyc, LAT - 1);
    check("t1_res", res_w[0], 16'h0300);
    check("t1_ovf", ovf_w[0], 0);
    consume();

    send(16'h0001, 16'h0080);
    wait_out(cyc);
    check("rnd_pos_round", res_w[0], 16'h0001);
    check("rnd_pos_trunc", res_w[1], 16'h0000);
    consume();
    send(16'hFFFF, 16'h0080);
    wait_out(cyc);
    check("rnd_neg_round", res_w[0], 16'h0000);
    check("rnd_neg_trunc", res_w[1], 16'hFFFF);
    consume();

    send(16'h7FFF, 16'h7FFF);
    wait_out(cyc);
    check("sat_pos_res", res_w[0], 16'h7FFF);
    check("sat_pos_ovf", ovf_w[0], 1);
    check("wrap_pos_res", res_w[2], 16'hFF00);
    check("wrap_pos_ovf", ovf_w[2], 1);
    consume();
    @(negedge clk);
    check("sticky_set", sticky[0], 1);
    @(posedge clk);
    #1;
    send(16'h8000, 16'h7FFF);
    wait_out(cyc);
    check("sat_neg_res", res_w[0], 16'h8000);
    check("sat_neg_ovf", ovf_w[0], 1);
    consume();
    send(16'h8000, 16'h8000);
    wait_out(cyc);
    check("negneg_res", res_w[0], 16'h7FFF);
    check("negneg_ovf", ovf_w[0], 1);
    consume();

    clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    @(negedge clk);
    check("sticky_clr", sticky, 3'b000);
    @(posedge clk);
    #1;
    send(16'h7FFF, 16'h7FFF);
    wait_out(cyc);
    clr_ovf = 1'b1;
    consume();
    clr_ovf = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", sticky, 3'b111);
    @(posedge clk);
    #1;

    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) send(rv(), rv());
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = res_w[0];
        check("bp_out_valid", out_valid, 1);
        check("bp_in_ready0", in_ready, 0);
        for (int i = 1; i < 4; i++) begin
          @(negedge clk);
          check($sformatf("bp_in_ready%0d", i), in_ready, 0);
          check($sformatf("bp_res_stable%0d", i), res_w[0], held);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 100 && n_out != n0 + 10; i++) @(posedge clk);
    #1;
    check("bp_count", n_out - n0, 10);
    check("bp_queue_empty", q_in.size(), 0);

    send(16'h0100, 16'h0200);
    send(16'h0300, 16'h0400);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sticky", sticky, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    n0 = n_out;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    repeat (8) @(negedge clk);
    check("post_rst_no_output", n_out - n0, 0);
    check("post_rst_busy", busy, 0);
    @(posedge clk);
    #1;

    done = 1'b0;
    fork
      begin
        for (int i = 0; i < NRAND; i++) begin
          if ($urandom % 4 == 0) begin
            repeat ($urandom_range(1, 3)) begin
              @(posedge clk);
              #1;
            end
          end
          send(rv(), rv());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom % 4) != 0;
          clr_ovf   = ($urandom % 16) == 0;
        end
      end
    join
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    for (int i = 0; i < 200 && q_in.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("rand_drain_empty", q_in.size(), 0);
    check("rand_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
